// File: rtl/vme_rdmux_pkg.sv
// rtl/vme_rdmux_pkg.sv - FSM states, index-width helper and default window constants
package vme_rdmux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } rdmux_state_e;

  localparam logic [7:0] DEF_BASE   = 8'h80;
  localparam int         DEF_STRIDE = 2;

  // Width of a register index; never less than one bit so NREG=1 still has a port.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/vme_reg_rdmux_if.sv
// rtl/vme_reg_rdmux_if.sv - read request/acknowledge bus between VME decoder and read-back mux
interface vme_reg_rdmux_if #(
  parameter int NREG = 13,
  parameter int DW   = 16,
  parameter int AW   = 8
);
  logic               RD;
  logic [AW-1:0]      ADDR;
  logic [NREG*DW-1:0] DIN;
  logic [DW-1:0]      DOUT;
  logic               ACK;
  logic               BERR;

  modport master (output RD, ADDR, DIN, input DOUT, ACK, BERR);
  modport slave  (input RD, ADDR, DIN, output DOUT, ACK, BERR);
endinterface

// File: rtl/vme_rdmux_decode.sv
// rtl/vme_rdmux_decode.sv - combinational address to {hit, index} decoder for the register window
module vme_rdmux_decode
  import vme_rdmux_pkg::*;
#(
  parameter int              NREG     = 13,
  parameter int              AW       = 8,
  parameter logic [AW-1:0]   BASE     = AW'(DEF_BASE),
  parameter int              STRIDE   = DEF_STRIDE,
  parameter logic [NREG-1:0] MAP_MASK = {NREG{1'b1}}
) (
  input  logic [AW-1:0]              addr,
  output logic                       hit,
  output logic [idx_width(NREG)-1:0] idx
);

  localparam int          IW     = idx_width(NREG);
  localparam int          MW     = 1 << IW;
  localparam logic [31:0] NREG_W = 32'(NREG);

  logic [AW-1:0] off;
  logic [AW-1:0] quot;
  logic [MW-1:0] mask_ext;

  // The explicit addr >= BASE term stops a below-window address aliasing through the wrap.
  always_comb begin
    off      = addr - BASE;
    quot     = off / AW'(STRIDE);
    mask_ext = '0;
    mask_ext[NREG-1:0] = MAP_MASK;
    idx      = quot[IW-1:0];
    hit      = (addr >= BASE) && ((off % AW'(STRIDE)) == '0) &&
               (32'(quot) < NREG_W) && mask_ext[idx];
  end

endmodule

// File: rtl/vme_reg_rdmux.sv
// rtl/vme_reg_rdmux.sv - VME register read-back mux with wait states; VME_RDMUX_BERR_EN turns misses into BERR
module vme_reg_rdmux
  import vme_rdmux_pkg::*;
#(
  parameter int              NREG     = 13,
  parameter int              DW       = 16,
  parameter int              AW       = 8,
  parameter logic [AW-1:0]   BASE     = AW'(DEF_BASE),
  parameter int              STRIDE   = DEF_STRIDE,
  parameter logic [NREG-1:0] MAP_MASK = {NREG{1'b1}},
  parameter int              LAT      = 1
) (
  input  logic           CLK,
  input  logic           RST_N,
  vme_reg_rdmux_if.slave bus
);

  localparam int IW = idx_width(NREG);
`ifdef VME_RDMUX_BERR_EN
  localparam bit BERR_EN = 1'b1;
`else
  localparam bit BERR_EN = 1'b0;
`endif

  rdmux_state_e  state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          hit_q, hit_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          ack_q, ack_d;
  logic          berr_q, berr_d;

  logic          dec_hit;
  logic [IW-1:0] dec_idx;
  logic          sel_hit;
  logic [IW-1:0] sel_idx;
  logic [DW-1:0] sel_word;
  logic          go_ack;

  vme_rdmux_decode #(
    .NREG(NREG), .AW(AW), .BASE(BASE), .STRIDE(STRIDE), .MAP_MASK(MAP_MASK)
  ) u_decode (
    .addr(bus.ADDR),
    .hit (dec_hit),
    .idx (dec_idx)
  );

  // With LAT=0 the ACK entry edge is the capture edge, so the live decode is used there.
  always_comb begin
    sel_hit  = (state_q == ST_IDLE) ? dec_hit : hit_q;
    sel_idx  = (state_q == ST_IDLE) ? dec_idx : idx_q;
    sel_word = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel_idx == IW'(i)) sel_word = bus.DIN[i*DW +: DW];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    ack_d   = ack_q;
    berr_d  = berr_q;
    go_ack  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.RD) begin
          hit_d = dec_hit;
          idx_d = dec_idx;
          cnt_d = 3'(LAT);
          if (LAT == 0) begin
            state_d = ST_ACK;
            go_ack  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.RD) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = ST_ACK;
            go_ack  = 1'b1;
          end
        end
      end
      ST_ACK: begin
        if (!bus.RD) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
          berr_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (go_ack) begin
      dout_d = sel_hit ? sel_word : '0;
      ack_d  = sel_hit || !BERR_EN;
      berr_d = !sel_hit && BERR_EN;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      berr_q  <= berr_d;
    end
  end

  assign bus.DOUT = dout_q;
  assign bus.ACK  = ack_q;
  assign bus.BERR = BERR_EN ? berr_q : 1'b0;

endmodule

// File: tb/tb_vme_reg_rdmux.sv
// tb/tb_vme_reg_rdmux.sv - scoreboard bench driving four mux instances at LAT 0, 1, 3 and 7
module tb_vme_reg_rdmux;

  localparam int              NREG = 13;
  localparam int              DW   = 16;
  localparam int              AW   = 8;
  localparam int              ND   = 4;
  localparam logic [NREG-1:0] MASK = 13'h1DFF;
  localparam int              LATS [ND] = '{0, 1, 3, 7};
`ifdef VME_RDMUX_BERR_EN
  localparam bit BERR_EN = 1'b1;
`else
  localparam bit BERR_EN = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] dout;
    bit            ack;
    bit            berr;
    int            due;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [ND-1:0]      rd;
  logic [AW-1:0]      addr;
  logic [NREG*DW-1:0] din;
  logic [DW-1:0]      regs [NREG];
  logic [DW-1:0]      dout [ND];
  logic [ND-1:0]      ack;
  logic [ND-1:0]      berr;

  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  exp_t          sb [ND][$];
  bit            prev_act [ND];
  logic [DW-1:0] held [ND];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb for (int i = 0; i < NREG; i++) din[i*DW +: DW] = regs[i];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    vme_reg_rdmux_if #(.NREG(NREG), .DW(DW), .AW(AW)) bus ();
    assign bus.RD   = rd[g];
    assign bus.ADDR = addr;
    assign bus.DIN  = din;
    assign dout[g]  = bus.DOUT;
    assign ack[g]   = bus.ACK;
    assign berr[g]  = bus.BERR;
    vme_reg_rdmux #(
      .NREG(NREG), .DW(DW), .AW(AW), .BASE(8'h80), .STRIDE(2),
      .MAP_MASK(MASK), .LAT(LATS[g])
    ) u_dut (
      .CLK  (clk),
      .RST_N(rst_n),
      .bus  (bus)
    );
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference decode in plain integer arithmetic: no wrap, so below-BASE is simply negative.
  function automatic exp_t model(logic [AW-1:0] a);
    exp_t e;
    int   off;
    bit   hit;
    off = int'(a) - 'h80;
    hit = (off >= 0) && (off % 2 == 0) && (off / 2 < NREG);
    if (hit) hit = MASK[off/2];
    e.dout = '0;
    if (hit) e.dout = regs[off/2];
    e.ack  = hit || !BERR_EN;
    e.berr = !hit && BERR_EN;
    e.due  = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < ND; k++) begin
      if (ack[k] || berr[k]) begin
        check($sformatf("ack_berr_excl%0d", k), {31'd0, ack[k] & berr[k]}, 0);
        if (!prev_act[k]) begin
          if (sb[k].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack%0d: got ack=%0b berr=%0b with no request", k, ack[k], berr[k]);
          end else begin
            e = sb[k].pop_front();
            check($sformatf("dout%0d", k), dout[k], e.dout);
            check($sformatf("ack%0d", k), ack[k], e.ack);
            check($sformatf("berr%0d", k), berr[k], e.berr);
            check($sformatf("latency%0d", k), cyc, e.due);
            held[k] = e.dout;
          end
        end else begin
          check($sformatf("dout_hold%0d", k), dout[k], held[k]);
        end
      end
      prev_act[k] = ack[k] || berr[k];
    end
  end

  task automatic wait_act(int k);
    for (int i = 0; i < 12 && !(ack[k] || berr[k]); i++) @(negedge clk);
    check($sformatf("ack_timeout%0d", k), {31'd0, ack[k] | berr[k]}, 1);
  endtask

  task automatic do_read(int k, logic [AW-1:0] a, int hold, bit chg);
    exp_t e;
    int   issue;
    bit   late;
    late = chg && (LATS[k] > 0);
    @(negedge clk);
    addr  = a;
    rd[k] = 1'b1;
    issue = cyc;
    if (!late) begin
      e = model(a);
      e.due = issue + LATS[k] + 1;
      sb[k].push_back(e);
    end
    @(negedge clk);
    addr = AW'($urandom);
    if (late) begin
      for (int i = 0; i < NREG; i++) regs[i] = DW'($urandom);
      e = model(a);
      e.due = issue + LATS[k] + 1;
      sb[k].push_back(e);
    end
    wait_act(k);
    repeat (hold) @(negedge clk);
    rd[k] = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("release%0d", k), {30'd0, ack[k], berr[k]}, 0);
  endtask

  initial begin
    exp_t e;
    int   issue;
    logic [AW-1:0] misses [6];
    misses = '{8'h81, 8'h7E, 8'h9A, 8'hA6, 8'h92, 8'h00};
    rd   = '0;
    addr = '0;
    for (int i = 0; i < NREG; i++) regs[i] = DW'($urandom);
    for (int k = 0; k < ND; k++) prev_act[k] = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      check($sformatf("rst_dout%0d", k), dout[k], 0);
      check($sformatf("rst_ack%0d", k), ack[k], 0);
      check($sformatf("rst_berr%0d", k), berr[k], 0);
    end
    rst_n = 1'b1;

    regs[0] = 16'h1234;
    regs[4] = 16'hBEEF;
    for (int k = 0; k < ND; k++) begin
      do_read(k, 8'h80, 0, 1'b0);
      do_read(k, 8'h88, 2, 1'b0);
      for (int m = 0; m < 6; m++) do_read(k, misses[m], 1, 1'b0);
      do_read(k, 8'h88, 0, 1'b1);
      regs[0] = 16'h1234;
      regs[4] = 16'hBEEF;
    end

    // Abort in the second wait cycle of the LAT=3 instance.
    do_read(2, 8'h80, 0, 1'b0);
    @(negedge clk);
    addr  = 8'h88;
    rd[2] = 1'b1;
    repeat (2) @(negedge clk);
    rd[2] = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_dout", dout[2], 16'h1234);
    check("abort_ack", {30'd0, ack[2], berr[2]}, 0);
    do_read(2, 8'h88, 0, 1'b0);

    // Reset while the LAT=1 instance holds ACK, with RD still high through reset release.
    @(negedge clk);
    addr  = 8'h88;
    rd[1] = 1'b1;
    issue = cyc;
    e = model(8'h88);
    e.due = issue + 2;
    sb[1].push_back(e);
    wait_act(1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ack_dout", dout[1], 0);
    check("rst_ack_flags", {30'd0, ack[1], berr[1]}, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("rst_wins_rd", {30'd0, ack[1], berr[1]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue = cyc;
    e = model(8'h88);
    e.due = issue + 2;
    sb[1].push_back(e);
    wait_act(1);
    rd[1] = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_release", {30'd0, ack[1], berr[1]}, 0);

    for (int n = 0; n < 60; n++) begin
      int            k;
      logic [AW-1:0] a;
      k = $urandom_range(ND - 1);
      for (int i = 0; i < NREG; i++) regs[i] = DW'($urandom);
      if ($urandom_range(1) == 1) a = AW'(8'h80 + $urandom_range(27));
      else a = AW'($urandom);
      do_read(k, a, $urandom_range(2), $urandom_range(3) == 0);
    end

    repeat (4) @(negedge clk);
    for (int k = 0; k < ND; k++) check($sformatf("sb_empty%0d", k), sb[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
